// File: rtl/idt_clkgen_prog.sv
// -----------------------------------------------------------------------------
// idt_clkgen_prog
// Serial programmer for the IDT ICS307 clock synthesizer (vo_clk source).
// Takes a 24-bit config word over a valid/ready handshake and shifts it out
// MSB-first on idt_sclk/idt_data. It then pulses idt_strobe and waits for the
// PLL to settle before it raises locked.
//
// Optional feature macro: IDT_AUTOLOAD_EN
//   defined   : reset lands in SHIFT_LO with DEFAULT_CFG loaded, so the
//               default frequency is programmed right after reset release.
//   undefined : reset lands in IDLE and nothing is shifted until cfg_valid.
// -----------------------------------------------------------------------------
module idt_clkgen_prog #(
  parameter int          CLK_DIV     = 4,
  parameter int          LOCK_CYCLES = 100000,
  parameter logic [23:0] DEFAULT_CFG = 24'h31149F
) (
  input  logic        osc_clk,
  input  logic        osc_reset_,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [23:0] cfg_word,
  output logic        idt_sclk,
  output logic        idt_data,
  output logic        idt_strobe,
  output logic        busy,
  output logic        locked
);

  localparam int DIV_W  = $clog2(CLK_DIV + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [4:0]        LAST_BIT  = 5'd23;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT_LO  = 3'd1,
    ST_SHIFT_HI  = 3'd2,
    ST_STROBE    = 3'd3,
    ST_LOCK_WAIT = 3'd4
  } state_t;

`ifdef IDT_AUTOLOAD_EN
  localparam state_t RST_STATE = ST_SHIFT_LO;
  localparam logic   RST_BUSY  = 1'b1;
  localparam logic   RST_DATA  = DEFAULT_CFG[23];
`else
  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_BUSY  = 1'b0;
  localparam logic   RST_DATA  = 1'b0;
`endif

  // The shift register always resets to DEFAULT_CFG. In the non-autoload
  // build this value never reaches the pins, because IDLE reloads it first.
  localparam logic [23:0] RST_SHREG = DEFAULT_CFG;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [23:0]         r_shreg;
  logic [23:0]         w_shreg_nxt;
  logic [4:0]          r_bit_cnt;
  logic [4:0]          w_bit_cnt_nxt;
  logic [DIV_W-1:0]    r_div_cnt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [LOCK_W-1:0]   w_lock_nxt;
  logic                r_strobe_half;
  logic                w_strobe_half_nxt;
  logic                r_sclk;
  logic                w_sclk_nxt;
  logic                r_data;
  logic                w_data_nxt;
  logic                r_strobe;
  logic                w_strobe_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_locked;
  logic                w_locked_nxt;
  logic                w_div_done;
  logic                w_lock_done;

  assign w_div_done  = (r_div_cnt == DIV_LAST);
  assign w_lock_done = (r_lock_cnt == LOCK_LAST);

  assign cfg_ready  = (r_state == ST_IDLE);
  assign idt_sclk   = r_sclk;
  assign idt_data   = r_data;
  assign idt_strobe = r_strobe;
  assign busy       = r_busy;
  assign locked     = r_locked;

  // Next-state, datapath and registered-output next values.
  always_comb begin
    w_state_nxt       = r_state;
    w_shreg_nxt       = r_shreg;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_strobe_half_nxt = r_strobe_half;
    w_busy_nxt        = r_busy;
    w_locked_nxt      = r_locked;
    w_div_nxt         = {DIV_W{1'b0}};
    w_lock_nxt        = {LOCK_W{1'b0}};

    case (r_state)
      ST_IDLE: begin
        if (cfg_valid) begin
          w_state_nxt   = ST_SHIFT_LO;
          w_shreg_nxt   = cfg_word;
          w_bit_cnt_nxt = 5'd0;
          w_locked_nxt  = 1'b0;
          w_busy_nxt    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        if (w_div_done) begin
          w_state_nxt = ST_SHIFT_HI;
        end else begin
          w_state_nxt = ST_SHIFT_LO;
        end
      end
      ST_SHIFT_HI: begin
        if (w_div_done) begin
          // Shifting here, when sclk is about to fall, keeps data stable while sclk is high.
          w_shreg_nxt   = {r_shreg[22:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt + 5'd1;
          if (r_bit_cnt == LAST_BIT) begin
            w_state_nxt       = ST_STROBE;
            w_strobe_half_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_SHIFT_LO;
          end
        end else begin
          w_state_nxt = ST_SHIFT_HI;
        end
      end
      ST_STROBE: begin
        // Strobe spans two half-periods; r_strobe_half marks the second one.
        if (w_div_done) begin
          if (r_strobe_half) begin
            w_state_nxt = ST_LOCK_WAIT;
          end else begin
            w_strobe_half_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = ST_STROBE;
        end
      end
      ST_LOCK_WAIT: begin
        if (w_lock_done) begin
          w_state_nxt  = ST_IDLE;
          w_locked_nxt = 1'b1;
          w_busy_nxt   = 1'b0;
        end else begin
          w_state_nxt = ST_LOCK_WAIT;
        end
      end
      default: begin
        w_state_nxt  = ST_IDLE;
        w_busy_nxt   = 1'b0;
        w_locked_nxt = 1'b0;
      end
    endcase

    // Counters restart on every state entry and run only in their own states.
    if (w_state_nxt != r_state) begin
      w_div_nxt  = {DIV_W{1'b0}};
      w_lock_nxt = {LOCK_W{1'b0}};
    end else begin
      if (r_state == ST_LOCK_WAIT) begin
        w_lock_nxt = r_lock_cnt + LOCK_W'(1);
      end else begin
        w_lock_nxt = {LOCK_W{1'b0}};
      end
      if ((r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) || (r_state == ST_STROBE)) begin
        if (w_div_done) begin
          w_div_nxt = {DIV_W{1'b0}};
        end else begin
          w_div_nxt = r_div_cnt + DIV_W'(1);
        end
      end else begin
        w_div_nxt = {DIV_W{1'b0}};
      end
    end

    // Pin values are decoded from the next state, so they register in step with it.
    w_sclk_nxt   = (w_state_nxt == ST_SHIFT_HI);
    w_strobe_nxt = (w_state_nxt == ST_STROBE);
    if ((w_state_nxt == ST_SHIFT_LO) || (w_state_nxt == ST_SHIFT_HI)) begin
      w_data_nxt = w_shreg_nxt[23];
    end else begin
      w_data_nxt = 1'b0;
    end
  end

  // State, datapath and output registers with asynchronous reset.
  always_ff @(posedge osc_clk or negedge osc_reset_) begin
    if (!osc_reset_) begin
      r_state       <= RST_STATE;
      r_shreg       <= RST_SHREG;
      r_bit_cnt     <= 5'd0;
      r_div_cnt     <= {DIV_W{1'b0}};
      r_lock_cnt    <= {LOCK_W{1'b0}};
      r_strobe_half <= 1'b0;
      r_sclk        <= 1'b0;
      r_data        <= RST_DATA;
      r_strobe      <= 1'b0;
      r_busy        <= RST_BUSY;
      r_locked      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_shreg       <= w_shreg_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_div_cnt     <= w_div_nxt;
      r_lock_cnt    <= w_lock_nxt;
      r_strobe_half <= w_strobe_half_nxt;
      r_sclk        <= w_sclk_nxt;
      r_data        <= w_data_nxt;
      r_strobe      <= w_strobe_nxt;
      r_busy        <= w_busy_nxt;
      r_locked      <= w_locked_nxt;
    end
  end

endmodule

// File: tb/tb_idt_clkgen_prog.sv
// -----------------------------------------------------------------------------
// tb_idt_clkgen_prog
// Instance A runs with CLK_DIV=2, LOCK_CYCLES=16. Instance F runs with
// CLK_DIV=1, LOCK_CYCLES=1. Each word handed to a DUT has its 24 bits pushed,
// MSB first, into that DUT's queue. A monitor pops and compares one bit at
// every rising idt_sclk. The same monitor checks data stability while sclk is
// high and checks the strobe pulse width.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idt_clkgen_prog;

  localparam logic [23:0] DEF_CFG = 24'h31149F;

  logic        osc_clk;
  logic        osc_reset_;
  logic        cfg_valid_a, cfg_ready_a, sclk_a, data_a, strobe_a, busy_a, locked_a;
  logic [23:0] cfg_word_a;
  logic        cfg_valid_f, cfg_ready_f, sclk_f, data_f, strobe_f, busy_f, locked_f;
  logic [23:0] cfg_word_f;

  int   n_tests = 0;
  int   n_fail  = 0;
  bit   q_a[$];
  bit   q_f[$];
  int   edges_a = 0, strobes_a = 0, edges_f = 0, strobes_f = 0;
  int   last_rise_f = -1;

  idt_clkgen_prog #(.CLK_DIV(2), .LOCK_CYCLES(16), .DEFAULT_CFG(DEF_CFG)) u_dut_a (
    .osc_clk(osc_clk), .osc_reset_(osc_reset_), .cfg_valid(cfg_valid_a), .cfg_ready(cfg_ready_a),
    .cfg_word(cfg_word_a), .idt_sclk(sclk_a), .idt_data(data_a), .idt_strobe(strobe_a),
    .busy(busy_a), .locked(locked_a));

  idt_clkgen_prog #(.CLK_DIV(1), .LOCK_CYCLES(1), .DEFAULT_CFG(DEF_CFG)) u_dut_f (
    .osc_clk(osc_clk), .osc_reset_(osc_reset_), .cfg_valid(cfg_valid_f), .cfg_ready(cfg_ready_f),
    .cfg_word(cfg_word_f), .idt_sclk(sclk_f), .idt_data(data_f), .idt_strobe(strobe_f),
    .busy(busy_f), .locked(locked_f));

  initial begin
    osc_clk = 1'b0;
    forever #5 osc_clk = ~osc_clk;
  end

  // Monitor for instance A: scoreboard pops, data stability, strobe width.
  initial begin
    bit prev_sclk = 1'b0, prev_data = 1'b0, exp_bit;
    int run = 0;
    forever begin
      @(negedge osc_clk);
      if (sclk_a && !prev_sclk) begin
        edges_a++;
        n_tests++;
        if (q_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_sclk_edge: unexpected rising edge %0d with data=%0b, required no edge", edges_a, data_a);
        end else begin
          exp_bit = q_a.pop_front();
          if (data_a !== exp_bit) begin
            n_fail++;
            $display("FAIL a_data_bit: edge %0d data=%0b, required %0b", edges_a, data_a, exp_bit);
          end
        end
        n_tests++;
        if (data_a !== prev_data) begin
          n_fail++;
          $display("FAIL a_data_setup: data=%0b at edge %0d, required %0b from cycle before", data_a, edges_a, prev_data);
        end
      end else if (sclk_a && prev_sclk) begin
        n_tests++;
        if (data_a !== prev_data) begin
          n_fail++;
          $display("FAIL a_data_hold: data changed to %0b while sclk high, required %0b", data_a, prev_data);
        end
      end
      if (strobe_a) begin
        run++;
      end else if (run != 0) begin
        strobes_a++;
        n_tests++;
        if (run != 4) begin
          n_fail++;
          $display("FAIL a_strobe_len: %0d cycles, required 4", run);
        end
        run = 0;
      end
      prev_sclk = sclk_a;
      prev_data = data_a;
    end
  end

  // Monitor for instance F: scoreboard pops, sclk period, data stability, strobe width.
  initial begin
    bit prev_sclk = 1'b0, prev_data = 1'b0, exp_bit;
    int run = 0, cyc = 0;
    forever begin
      @(negedge osc_clk);
      cyc++;
      if (sclk_f && !prev_sclk) begin
        edges_f++;
        n_tests++;
        if (q_f.size() == 0) begin
          n_fail++;
          $display("FAIL f_sclk_edge: unexpected rising edge %0d, required no edge", edges_f);
        end else begin
          exp_bit = q_f.pop_front();
          if (data_f !== exp_bit) begin
            n_fail++;
            $display("FAIL f_data_bit: edge %0d data=%0b, required %0b", edges_f, data_f, exp_bit);
          end
        end
        n_tests++;
        if (data_f !== prev_data) begin
          n_fail++;
          $display("FAIL f_data_setup: data=%0b at edge %0d, required %0b", data_f, edges_f, prev_data);
        end
        if (last_rise_f >= 0) begin
          n_tests++;
          if (cyc - last_rise_f != 2) begin
            n_fail++;
            $display("FAIL f_sclk_period: %0d cycles, required 2", cyc - last_rise_f);
          end
        end
        last_rise_f = cyc;
      end
      if (strobe_f) begin
        run++;
      end else if (run != 0) begin
        strobes_f++;
        n_tests++;
        if (run != 2) begin
          n_fail++;
          $display("FAIL f_strobe_len: %0d cycles, required 2", run);
        end
        run = 0;
      end
      prev_sclk = sclk_f;
      prev_data = data_f;
    end
  end

  // Wait for cfg_ready, push the expected bits and perform one handshake.
  task automatic send(input bit fast, input logic [23:0] w);
    int k = 0;
    while (!(fast ? cfg_ready_f : cfg_ready_a) && k < 4000) begin
      @(posedge osc_clk); #1;
      k++;
    end
    n_tests++;
    if (!(fast ? cfg_ready_f : cfg_ready_a)) begin
      n_fail++;
      $display("FAIL send_ready: cfg_ready=0 after %0d cycles, required 1", k);
    end
    for (int i = 23; i >= 0; i--) begin
      if (fast) q_f.push_back(w[i]);
      else      q_a.push_back(w[i]);
    end
    if (fast) begin cfg_word_f = w; cfg_valid_f = 1'b1; end
    else      begin cfg_word_a = w; cfg_valid_a = 1'b1; end
    @(posedge osc_clk); #1;
    cfg_valid_a = 1'b0;
    cfg_valid_f = 1'b0;
  endtask

  // Count cycles until locked rises, bounded.
  task automatic wait_locked(input bit fast, output int n);
    n = 0;
    while (!(fast ? locked_f : locked_a) && n < 4000) begin
      @(posedge osc_clk); #1;
      n++;
    end
    n_tests++;
    if (!(fast ? locked_f : locked_a)) begin
      n_fail++;
      $display("FAIL wait_locked: locked=0 after %0d cycles, required 1", n);
    end
  endtask

  // With autoload enabled, both instances program DEFAULT_CFG after reset release.
  task automatic after_reset();
`ifdef IDT_AUTOLOAD_EN
    int n;
    edges_a = 0; edges_f = 0; last_rise_f = -1;
    for (int i = 23; i >= 0; i--) begin
      q_a.push_back(DEF_CFG[i]);
      q_f.push_back(DEF_CFG[i]);
    end
    wait_locked(1'b0, n);
    wait_locked(1'b1, n);
    n_tests++;
    if (cfg_ready_a !== 1'b1 || cfg_ready_f !== 1'b1 || edges_a != 24 || edges_f != 24) begin
      n_fail++;
      $display("FAIL autoload: ready_a=%0b ready_f=%0b edges_a=%0d edges_f=%0d, required 1 1 24 24",
               cfg_ready_a, cfg_ready_f, edges_a, edges_f);
    end
`else
    @(posedge osc_clk); #1;
`endif
  endtask

  task automatic test_reset();
    logic [6:0] got, exp;
    got = {sclk_a, data_a, strobe_a, busy_a, locked_a, cfg_ready_a, locked_f};
`ifdef IDT_AUTOLOAD_EN
    exp = {1'b0, DEF_CFG[23], 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
`else
    exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`endif
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_state: {sclk,data,strobe,busy,locked,ready,locked_f}=%b, required %b", got, exp);
    end
  endtask

  task automatic test_single();
    int n;
    edges_a = 0; strobes_a = 0;
    send(1'b0, 24'h31149F);
    n_tests++;
    if ({locked_a, busy_a, cfg_ready_a} !== 3'b010) begin
      n_fail++;
      $display("FAIL single_accept: {locked,busy,ready}=%b, required 010", {locked_a, busy_a, cfg_ready_a});
    end
    wait_locked(1'b0, n);
    n_tests++;
    if (n < 115 || n > 117) begin
      n_fail++;
      $display("FAIL single_latency: %0d cycles, required 116", n);
    end
    n_tests++;
    if (edges_a != 24 || q_a.size() != 0 || strobes_a != 1) begin
      n_fail++;
      $display("FAIL single_counts: edges=%0d left=%0d strobes=%0d, required 24 0 1", edges_a, q_a.size(), strobes_a);
    end
    n_tests++;
    if ({cfg_ready_a, busy_a, sclk_a, strobe_a} !== 4'b1000) begin
      n_fail++;
      $display("FAIL single_idle: {ready,busy,sclk,strobe}=%b, required 1000", {cfg_ready_a, busy_a, sclk_a, strobe_a});
    end
  endtask

  task automatic test_back_to_back();
    int  n;
    bit  rdy, lk, acc = 1'b0;
    edges_a = 0; strobes_a = 0;
    send(1'b0, 24'hFFFFFF);
    cfg_word_a  = 24'h000000;
    cfg_valid_a = 1'b1;
    for (int k = 0; k < 400 && !acc; k++) begin
      rdy = cfg_ready_a;
      lk  = locked_a;
      @(posedge osc_clk); #1;
      if (rdy) begin
        acc = 1'b1;
        for (int i = 0; i < 24; i++) q_a.push_back(1'b0);
      end
    end
    cfg_valid_a = 1'b0;
    n_tests++;
    if (!acc || !lk || edges_a != 24) begin
      n_fail++;
      $display("FAIL b2b_accept: accepted=%0b locked_before=%0b edges=%0d, required 1 1 24", acc, lk, edges_a);
    end
    n_tests++;
    if ({locked_a, busy_a} !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_locked_drop: {locked,busy}=%b, required 01", {locked_a, busy_a});
    end
    wait_locked(1'b0, n);
    n_tests++;
    if (edges_a != 48 || q_a.size() != 0 || strobes_a != 2) begin
      n_fail++;
      $display("FAIL b2b_counts: edges=%0d left=%0d strobes=%0d, required 48 0 2", edges_a, q_a.size(), strobes_a);
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    int bad = 0;
    edges_a = 0; strobes_a = 0;
    send(1'b0, 24'h31149F);
    cfg_word_a  = 24'hA5A5A5;
    cfg_valid_a = 1'b1;
    for (int k = 0; k < 110; k++) begin
      if (cfg_ready_a !== 1'b0 || busy_a !== 1'b1) bad++;
      @(posedge osc_clk); #1;
    end
    cfg_valid_a = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL ignore_ready: %0d busy cycles with ready=1 or busy=0, required 0", bad);
    end
    wait_locked(1'b0, n);
    repeat (10) @(posedge osc_clk);
    #1;
    n_tests++;
    if (edges_a != 24 || q_a.size() != 0 || strobes_a != 1 || busy_a !== 1'b0 || locked_a !== 1'b1) begin
      n_fail++;
      $display("FAIL ignore_counts: edges=%0d left=%0d strobes=%0d busy=%0b locked=%0b, required 24 0 1 0 1",
               edges_a, q_a.size(), strobes_a, busy_a, locked_a);
    end
  endtask

  task automatic test_reset_mid();
    int n, k = 0;
    int strobes_before;
    edges_a = 0;
    send(1'b0, 24'h5A3C96);
    while (edges_a < 10 && k < 400) begin
      @(posedge osc_clk); #1;
      k++;
    end
    strobes_before = strobes_a;
    #2 osc_reset_ = 1'b0;
    #1;
    n_tests++;
    if ({sclk_a, data_a, strobe_a, locked_a} !== 4'b0000 || edges_a != 10) begin
      n_fail++;
      $display("FAIL midreset_async: {sclk,data,strobe,locked}=%b edges=%0d, required 0000 10",
               {sclk_a, data_a, strobe_a, locked_a}, edges_a);
    end
`ifndef IDT_AUTOLOAD_EN
    n_tests++;
    if (busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_busy: busy=%0b, required 0", busy_a);
    end
`endif
    q_a.delete();
    q_f.delete();
    repeat (3) @(posedge osc_clk);
    @(negedge osc_clk);
    osc_reset_ = 1'b1;
    @(posedge osc_clk); #1;
    n_tests++;
    if (strobes_a != strobes_before || edges_a != 10) begin
      n_fail++;
      $display("FAIL midreset_nostrobe: strobes=%0d edges=%0d, required %0d 10", strobes_a, edges_a, strobes_before);
    end
    after_reset();
    edges_a = 0; strobes_a = 0;
    send(1'b0, 24'h96C3A5);
    wait_locked(1'b0, n);
    n_tests++;
    if (edges_a != 24 || q_a.size() != 0 || strobes_a != 1) begin
      n_fail++;
      $display("FAIL midreset_reload: edges=%0d left=%0d strobes=%0d, required 24 0 1", edges_a, q_a.size(), strobes_a);
    end
  endtask

  task automatic test_fast();
    int n;
    edges_f = 0; strobes_f = 0; last_rise_f = -1;
    send(1'b1, 24'hC3A96E);
    wait_locked(1'b1, n);
    n_tests++;
    if (n < 50 || n > 52) begin
      n_fail++;
      $display("FAIL fast_latency: %0d cycles, required 51", n);
    end
    n_tests++;
    if (edges_f != 24 || q_f.size() != 0 || strobes_f != 1 || cfg_ready_f !== 1'b1) begin
      n_fail++;
      $display("FAIL fast_counts: edges=%0d left=%0d strobes=%0d ready=%0b, required 24 0 1 1",
               edges_f, q_f.size(), strobes_f, cfg_ready_f);
    end
  endtask

  // Watchdog so the run always ends even if the DUT hangs.
  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    osc_reset_  = 1'b0;
    cfg_valid_a = 1'b0; cfg_word_a = 24'h0;
    cfg_valid_f = 1'b0; cfg_word_f = 24'h0;
    repeat (3) @(posedge osc_clk);
    #1;
    test_reset();
    @(negedge osc_clk);
    osc_reset_ = 1'b1;
    @(posedge osc_clk); #1;
    after_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_reset_mid();
    test_fast();
    repeat (5) @(posedge osc_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
